// File: rtl/gmux_sel_ctrl.sv
// Select controller for the GMUX clock mux: gates downstream clock enable,
// flips the select in a quiet window, lets it settle, then re-enables and acks.
module gmux_sel_ctrl #(
    parameter int QUIESCE_CYCLES = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter bit RESET_SEL      = 1'b0,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             sel_req,
    output logic             is0,
    output logic             cen,
    output logic             busy,
    output logic             ack,
    output logic [CNT_W-1:0] switch_cnt
);

    // A zero-length window would let the select move in the same cycle the
    // enable drops, so both windows are at least one cycle long.
    localparam int Q_EFF    = (QUIESCE_CYCLES < 1) ? 1 : QUIESCE_CYCLES;
    localparam int S_EFF    = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int MAX_QS   = (Q_EFF > S_EFF) ? Q_EFF : S_EFF;
    localparam int TMR_SPAN = (MAX_QS > 2) ? MAX_QS : 2;
    localparam int TMR_W    = $clog2(TMR_SPAN);

    localparam logic [TMR_W-1:0] Q_LOAD = TMR_W'(Q_EFF - 1);
    localparam logic [TMR_W-1:0] S_LOAD = TMR_W'(S_EFF - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUIESCE = 2'd1,
        SETTLE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state_reg,  state_next;
    logic [TMR_W-1:0]   tmr_reg,    tmr_next;
    logic               target_reg, target_next;
    logic               is0_reg,    is0_next;
    logic               cen_reg,    cen_next;
    logic               busy_reg,   busy_next;
    logic               ack_reg,    ack_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            tmr_reg    <= '0;
            target_reg <= RESET_SEL;
            is0_reg    <= RESET_SEL;
            cen_reg    <= 1'b1;
            busy_reg   <= 1'b0;
            ack_reg    <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            tmr_reg    <= tmr_next;
            target_reg <= target_next;
            is0_reg    <= is0_next;
            cen_reg    <= cen_next;
            busy_reg   <= busy_next;
            ack_reg    <= ack_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    state_next = (sel_req != is0_reg) ? QUIESCE : DONE;
                end
            end
            QUIESCE: begin
                if (tmr_reg == '0) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered-output updates; the select only moves on QUIESCE -> SETTLE.
    always_comb begin
        tmr_next    = tmr_reg;
        target_next = target_reg;
        is0_next    = is0_reg;
        cen_next    = cen_reg;
        busy_next   = busy_reg;
        ack_next    = 1'b0;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (sel_req != is0_reg) begin
                        target_next = sel_req;
                        tmr_next    = Q_LOAD;
                        cen_next    = 1'b0;
                        busy_next   = 1'b1;
                    end else begin
                        ack_next = 1'b1;
                    end
                end
            end
            QUIESCE: begin
                if (tmr_reg == '0) begin
                    is0_next = target_reg;
                    tmr_next = S_LOAD;
                end else begin
                    tmr_next = tmr_reg - 1'b1;
                end
            end
            SETTLE: begin
                if (tmr_reg == '0) begin
                    cen_next  = 1'b1;
                    busy_next = 1'b0;
                    ack_next  = 1'b1;
                    cnt_next  = cnt_reg + 1'b1;
                end else begin
                    tmr_next = tmr_reg - 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign is0        = is0_reg;
    assign cen        = cen_reg;
    assign busy       = busy_reg;
    assign ack        = ack_reg;
    assign switch_cnt = cnt_reg;

endmodule

// File: tb/tb_gmux_sel_ctrl.sv
// Bench for gmux_sel_ctrl: each transaction is predicted from the latency rules
// (edge-indexed windows) and compared cycle by cycle.
module tb_gmux_sel_ctrl;

    localparam int Q    = 4;
    localparam int S    = 3;
    localparam int CW   = 2;
    localparam bit RSEL = 1'b0;
    localparam int QE   = (Q < 1) ? 1 : Q;
    localparam int SE   = (S < 1) ? 1 : S;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic          sel_req;
    logic          is0;
    logic          cen;
    logic          busy;
    logic          ack;
    logic [CW-1:0] switch_cnt;

    int compared   = 0;
    int mismatched = 0;
    bit m_is0;
    int m_cnt;

    always #5 clk = ~clk;

    gmux_sel_ctrl #(
        .QUIESCE_CYCLES(Q),
        .SETTLE_CYCLES (S),
        .RESET_SEL     (RSEL),
        .CNT_W         (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .sel_req   (sel_req),
        .is0       (is0),
        .cen       (cen),
        .busy      (busy),
        .ack       (ack),
        .switch_cnt(switch_cnt)
    );

    // Advance one edge; also checks the select never moves while enabled.
    task automatic tick();
        logic pre_is0, pre_cen;
        pre_is0 = is0;
        pre_cen = cen;
        @(posedge clk);
        #1;
        if (pre_cen === 1'b1 && rst_n) begin
            compared++;
            if (is0 !== pre_is0) begin
                mismatched++;
                $display("FAIL is0_while_cen: got %b want %b", is0, pre_is0);
            end
        end
    endtask

    task automatic do_switch(input bit sel, input bit churn, input bit hold, input string tag);
        bit old_is0, is_real, e_cen, e_busy, e_is0, e_ack;
        int lat;
        old_is0 = m_is0;
        is_real = (sel != m_is0);
        lat     = is_real ? QE + SE + 1 : 1;
        req     = 1'b1;
        sel_req = sel;
        for (int k = 1; k <= lat; k++) begin
            tick();
            if (churn && k >= 2 && k < lat) begin
                req     = 1'($urandom_range(0, 1));
                sel_req = ~sel;
            end
            if (k == lat) begin
                req     = hold;
                sel_req = hold ? ~sel : sel;
            end
            e_busy = is_real && (k < lat);
            e_cen  = !e_busy;
            e_is0  = (is_real && k > QE) ? sel : old_is0;
            e_ack  = (k == lat);
            compared += 4;
            if (cen !== e_cen) begin
                mismatched++;
                $display("FAIL %s cen edge %0d: got %b want %b", tag, k, cen, e_cen);
            end
            if (busy !== e_busy) begin
                mismatched++;
                $display("FAIL %s busy edge %0d: got %b want %b", tag, k, busy, e_busy);
            end
            if (is0 !== e_is0) begin
                mismatched++;
                $display("FAIL %s is0 edge %0d: got %b want %b", tag, k, is0, e_is0);
            end
            if (ack !== e_ack) begin
                mismatched++;
                $display("FAIL %s ack edge %0d: got %b want %b", tag, k, ack, e_ack);
            end
        end
        m_is0 = sel;
        if (is_real) m_cnt = (m_cnt + 1) % (1 << CW);
        compared++;
        if (switch_cnt !== CW'(m_cnt)) begin
            mismatched++;
            $display("FAIL %s switch_cnt: got %0d want %0d", tag, switch_cnt, m_cnt);
        end
        tick();
        compared += 4;
        if (ack !== 1'b0) begin
            mismatched++;
            $display("FAIL %s ack_after_done: got %b want 0", tag, ack);
        end
        if (cen !== 1'b1) begin
            mismatched++;
            $display("FAIL %s cen_after_done: got %b want 1", tag, cen);
        end
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s busy_after_done: got %b want 0", tag, busy);
        end
        if (is0 !== m_is0) begin
            mismatched++;
            $display("FAIL %s is0_after_done: got %b want %b", tag, is0, m_is0);
        end
        $display("txn %s sel=%0d real=%0d lat=%0d cnt=%0d is0=%0d", tag, sel, is_real, lat, switch_cnt, is0);
    endtask

    // Asserts reset a few ns into a cycle and checks outputs before any edge.
    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        compared += 5;
        if (is0 !== RSEL) begin
            mismatched++;
            $display("FAIL %s rst_is0: got %b want %b", tag, is0, RSEL);
        end
        if (cen !== 1'b1) begin
            mismatched++;
            $display("FAIL %s rst_cen: got %b want 1", tag, cen);
        end
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s rst_busy: got %b want 0", tag, busy);
        end
        if (ack !== 1'b0) begin
            mismatched++;
            $display("FAIL %s rst_ack: got %b want 0", tag, ack);
        end
        if (switch_cnt !== '0) begin
            mismatched++;
            $display("FAIL %s rst_cnt: got %0d want 0", tag, switch_cnt);
        end
        req = 1'b0;
        tick();
        #3;
        rst_n = 1'b1;
        m_is0 = RSEL;
        m_cnt = 0;
        $display("txn %s reset applied", tag);
    endtask

    task automatic test_reset();
        do_switch(~m_is0, 1'b0, 1'b0, "pre_reset");
        req     = 1'b1;
        sel_req = ~m_is0;
        tick();
        tick();
        pulse_reset("reset");
    endtask

    task automatic test_real_switch();
        do_switch(1'b1, 1'b0, 1'b0, "real_switch");
    endtask

    task automatic test_same_select();
        do_switch(m_is0, 1'b0, 1'b0, "same_select");
    endtask

    task automatic test_churn();
        do_switch(~m_is0, 1'b1, 1'b0, "churn");
    endtask

    task automatic test_abort();
        if (m_is0 != RSEL) pulse_reset("abort_prep");
        req     = 1'b1;
        sel_req = ~RSEL;
        for (int k = 1; k <= QE + 2; k++) tick();
        req = 1'b0;
        compared++;
        if (is0 !== ~RSEL) begin
            mismatched++;
            $display("FAIL abort is0_in_settle: got %b want %b", is0, ~RSEL);
        end
        pulse_reset("abort");
        for (int k = 0; k < QE + SE + 2; k++) begin
            tick();
            compared++;
            if (ack !== 1'b0) begin
                mismatched++;
                $display("FAIL abort ack_after_abort cycle %0d: got %b want 0", k, ack);
            end
        end
        do_switch(~m_is0, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back();
        do_switch(~m_is0, 1'b0, 1'b1, "b2b_a");
        do_switch(~m_is0, 1'b0, 1'b0, "b2b_b");
    endtask

    task automatic test_wrap();
        pulse_reset("wrap_prep");
        for (int i = 0; i < 5; i++) do_switch(~m_is0, 1'b0, 1'b0, "wrap");
    endtask

    task automatic test_random();
        bit s, c, h;
        for (int i = 0; i < 16; i++) begin
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            h = (i < 15) && ($urandom_range(0, 3) == 0);
            do_switch(s, c, 1'b0, "random");
            if (h) begin
                req     = 1'b1;
                sel_req = ~m_is0;
                do_switch(~m_is0, 1'b0, 1'b0, "random_b2b");
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 1'b0;
        sel_req = 1'b0;
        m_is0   = RSEL;
        m_cnt   = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        test_reset();
        test_real_switch();
        test_same_select();
        test_churn();
        test_abort();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
